// File: rtl/rx_cmd_pkg.sv
// Shared types and constants for the framed command receive path.
package rx_cmd_pkg;

  typedef enum logic [1:0] {
    PHY_IDLE,
    PHY_START,
    PHY_DATA,
    PHY_STOP
  } phy_st_e;

  typedef enum logic [2:0] {
    DEC_HUNT,
    DEC_DEV,
    DEC_MOD,
    DEC_ADDR,
    DEC_DATA,
    DEC_CHK
  } dec_st_e;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam int         TMO_W    = 16;
  localparam int         PER_W    = 20;

  function automatic logic dev_match(input logic [7:0] dev, input logic [7:0] own);
    return (dev == own) || (dev == BCAST_ID);
  endfunction

endpackage

// File: rtl/rx_cmd_frame_if.sv
// Command/error output bundle from the frame receiver to the dispatcher.
interface rx_cmd_frame_if #(
  parameter int DATA_BYTES = 1
);
  logic [7:0]              cmdr_dev;
  logic [7:0]              cmdr_mod;
  logic [7:0]              cmdr_addr;
  logic [8*DATA_BYTES-1:0] cmdr_data;
  logic                    cmdr_vld;
  logic                    err_chk;
  logic                    err_frame;
  logic                    err_tmo;

  modport master (
    output cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data,
    output cmdr_vld, err_chk, err_frame, err_tmo
  );

  modport slave (
    input cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data,
    input cmdr_vld, err_chk, err_frame, err_tmo
  );
endinterface

// File: rtl/rx_frame_phy.sv
// UART bit-level receiver: 2-FF synchroniser, mid-bit sampling, 8N1 byte output.
module rx_frame_phy
  import rx_cmd_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [PER_W-1:0] tbit_period,
  output logic             byte_vld,
  output logic [7:0]       rx_byte,
  output logic             frame_err
);

  logic [2:0]       rx_sync_q;
  phy_st_e          st_q;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             byte_vld_q;
  logic [7:0]       rx_byte_q;
  logic             frame_err_q;

  logic             rx_s;
  logic             fall;
  logic [PER_W-1:0] half;
  logic             bit_end;

  // Sync flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= 3'b111;
    else        rx_sync_q <= {rx_sync_q[1:0], rx};
  end

  always_comb begin
    rx_s    = rx_sync_q[1];
    fall    = rx_sync_q[2] & ~rx_sync_q[1];
    half    = {1'b0, per_q[PER_W-1:1]};
    bit_end = (cnt_q == per_q - {{(PER_W-1){1'b0}}, 1'b1});
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= PHY_IDLE;
      per_q       <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_vld_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (st_q)
        PHY_IDLE: begin
          if (fall) begin
            per_q <= tbit_period;
            cnt_q <= '0;
            st_q  <= PHY_START;
          end
        end
        PHY_START: begin
          if (cnt_q == half) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            st_q      <= rx_s ? PHY_IDLE : PHY_DATA;
          end else begin
            cnt_q <= cnt_q + {{(PER_W-1){1'b0}}, 1'b1};
          end
        end
        PHY_DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_s, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) st_q <= PHY_STOP;
          end else begin
            cnt_q <= cnt_q + {{(PER_W-1){1'b0}}, 1'b1};
          end
        end
        PHY_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_vld_q <= 1'b1;
              rx_byte_q  <= shreg_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            st_q <= PHY_IDLE;
          end else begin
            cnt_q <= cnt_q + {{(PER_W-1){1'b0}}, 1'b1};
          end
        end
        default: st_q <= PHY_IDLE;
      endcase
    end
  end

  assign byte_vld  = byte_vld_q;
  assign rx_byte   = rx_byte_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/rx_cmd_frame.sv
// Framed command decoder: sync hunt, field capture, checksum, device filter, inter-byte timeout.
module rx_cmd_frame
  import rx_cmd_pkg::*;
#(
  parameter int          DATA_BYTES = 1,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_DEF,
  parameter logic [7:0]  DEV_ID     = 8'h03,
  parameter int unsigned TMO_US     = 2000
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             pluse_us,
  input  logic             rx,
  input  logic [PER_W-1:0] tbit_period,
  rx_cmd_frame_if.master   cmd
);

  localparam int DW = 8 * DATA_BYTES;

  logic       byte_vld;
  logic [7:0] rx_byte;
  logic       frame_err;

  rx_frame_phy u_phy (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .rx          (rx),
    .tbit_period (tbit_period),
    .byte_vld    (byte_vld),
    .rx_byte     (rx_byte),
    .frame_err   (frame_err)
  );

  dec_st_e          st_q;
  logic [1:0]       cnt_q;
  logic [7:0]       sum_q;
  logic [7:0]       dev_q, mod_q, addr_q;
  logic [DW-1:0]    data_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       cmdr_dev_q, cmdr_mod_q, cmdr_addr_q;
  logic [DW-1:0]    cmdr_data_q;
  logic             cmdr_vld_q, err_chk_q, err_frame_q, err_tmo_q;

  logic [7:0]       sum_d;
  logic             tmo_hit;
  logic             last_data;

  always_comb begin
    sum_d     = sum_q + rx_byte;
    tmo_hit   = pluse_us && (tmo_q == TMO_W'(TMO_US - 1));
    last_data = (cnt_q == 2'(DATA_BYTES - 1));
  end

  // Frame error outranks everything; a byte always outranks the timeout.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= DEC_HUNT;
      cnt_q       <= '0;
      sum_q       <= '0;
      dev_q       <= '0;
      mod_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      cmdr_dev_q  <= '0;
      cmdr_mod_q  <= '0;
      cmdr_addr_q <= '0;
      cmdr_data_q <= '0;
      cmdr_vld_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      cmdr_vld_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      if (frame_err) begin
        err_frame_q <= 1'b1;
        st_q        <= DEC_HUNT;
        tmo_q       <= '0;
      end else if (byte_vld) begin
        tmo_q <= '0;
        case (st_q)
          DEC_HUNT: begin
            if (rx_byte == SYNC_BYTE) begin
              sum_q <= '0;
              st_q  <= DEC_DEV;
            end
          end
          DEC_DEV: begin
            dev_q <= rx_byte;
            sum_q <= sum_d;
            st_q  <= DEC_MOD;
          end
          DEC_MOD: begin
            mod_q <= rx_byte;
            sum_q <= sum_d;
            st_q  <= DEC_ADDR;
          end
          DEC_ADDR: begin
            addr_q <= rx_byte;
            sum_q  <= sum_d;
            cnt_q  <= '0;
            st_q   <= DEC_DATA;
          end
          DEC_DATA: begin
            for (int i = 0; i < DATA_BYTES; i++)
              if (cnt_q == 2'(i)) data_q[i*8 +: 8] <= rx_byte;
            sum_q <= sum_d;
            cnt_q <= cnt_q + 2'd1;
            if (last_data) st_q <= DEC_CHK;
          end
          DEC_CHK: begin
            if (rx_byte != sum_q) begin
              err_chk_q <= 1'b1;
            end else if (dev_match(dev_q, DEV_ID)) begin
              cmdr_dev_q  <= dev_q;
              cmdr_mod_q  <= mod_q;
              cmdr_addr_q <= addr_q;
              cmdr_data_q <= data_q;
              cmdr_vld_q  <= 1'b1;
            end
            st_q <= DEC_HUNT;
          end
          default: st_q <= DEC_HUNT;
        endcase
      end else if (st_q == DEC_HUNT) begin
        tmo_q <= '0;
      end else if (tmo_hit) begin
        err_tmo_q <= 1'b1;
        st_q      <= DEC_HUNT;
        tmo_q     <= '0;
      end else if (pluse_us) begin
        tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cmd.cmdr_dev  = cmdr_dev_q;
  assign cmd.cmdr_mod  = cmdr_mod_q;
  assign cmd.cmdr_addr = cmdr_addr_q;
  assign cmd.cmdr_data = cmdr_data_q;
  assign cmd.cmdr_vld  = cmdr_vld_q;
  assign cmd.err_chk   = err_chk_q;
  assign cmd.err_frame = err_frame_q;
  assign cmd.err_tmo   = err_tmo_q;

endmodule

// File: doc/rx_cmd_frame.md
Name: rx_cmd_frame

Overview:
- Parametrised successor of the RS-485 control receive path: bit-level UART receiver plus framed command decoder.
- Adds a sync byte, a variable-length data field, a checksum, device filtering with broadcast, an inter-byte timeout and error reporting.
- Sits between the rx_ctrl line pin and the command dispatcher in control_top.
- Delivers one validated command per frame as a single-cycle strobe.

Parameters:
- DATA_BYTES, 1, payload bytes per frame (1..4); cmdr_data width = 8*DATA_BYTES.
- SYNC_BYTE, 8'hA5, frame start marker.
- DEV_ID, 8'h03, own device address; 8'hFF is always accepted as broadcast.
- TMO_US, 2000, inter-byte timeout in pluse_us ticks (counter 16 bits).

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pluse_us  in  1  one-clk_sys pulse every microsecond.
- rx  in  1  RS-485 receive line, idle high, asynchronous to clk_sys.
- tbit_period  in  20  clk_sys cycles per bit; legal range >= 4; 10 in simulation.
- cmdr_dev  out  8  device byte of last accepted frame.
- cmdr_mod  out  8  module byte.
- cmdr_addr  out  8  register address byte.
- cmdr_data  out  8*DATA_BYTES  payload; first received byte in the LSBs.
- cmdr_vld  out  1  one-cycle strobe, accepted frame.
- err_chk  out  1  one-cycle strobe, checksum mismatch.
- err_frame  out  1  one-cycle strobe, stop bit sampled low.
- err_tmo  out  1  one-cycle strobe, inter-byte timeout.

Behaviour:
- Reset: all outputs 0; phy in IDLE; decoder in HUNT; counters 0.
- Phy input: rx passes a 2-FF synchroniser. Phy states:
  - IDLE: on a synchronised falling edge, latch tbit_period and go to START.
  - START: at half period, rx still low -> DATA; rx high -> IDLE (glitch, no output).
  - DATA: sample 8 bits at mid-bit, LSB first.
  - STOP: sample at mid-bit. High -> byte_vld pulse for 1 cycle with byte. Low -> frame-error pulse. Both return to IDLE.
  - Hunting for the next falling edge restarts immediately after the stop sample.
- Decoder FSM: HUNT -> DEV -> MOD -> ADDR -> DATA (DATA_BYTES bytes, byte counter) -> CHK -> HUNT.
  - HUNT advances only on byte == SYNC_BYTE; all other bytes are discarded.
  - SYNC_BYTE appearing mid-frame is treated as ordinary data; there is no resync.
- Checksum: 8-bit sum mod 256 of DEV, MOD, ADDR and DATA bytes; SYNC is excluded. Accumulator clears on entering DEV.
- On the CHK byte:
  - Sum matches and dev == DEV_ID or dev == 8'hFF: register all fields and pulse cmdr_vld in the cycle after the CHK byte_vld.
  - Sum matches, other dev: silently drop.
  - Sum mismatches: pulse err_chk, whatever the dev byte.
  - In the drop and mismatch cases cmdr_* hold their previous values.
- cmdr_* fields change only on acceptance. They are stable from the cmdr_vld cycle until the next acceptance.
- Phy frame error in any state: pulse err_frame; decoder returns to HUNT. A frame error while in HUNT still pulses err_frame.
- Timeout: counter clears on every byte_vld and increments on pluse_us while not in HUNT. Reaching TMO_US -> err_tmo pulse, decoder to HUNT, counter clears. Counter is held at 0 in HUNT.
- Simultaneous events:
  - byte_vld and the timeout terminal count in the same cycle: the byte wins and the counter clears.
  - byte_vld and a frame error cannot coincide.
- Error strobes and cmdr_vld never assert in the same cycle.
- Reset mid-frame: everything returns to reset values immediately, including cmdr_* fields.

Decomposition:
- Shared package rx_cmd_pkg: decoder and phy state encodings, default SYNC_BYTE, broadcast constant 8'hFF, TMO counter width.
- One sub-module, rx_frame_phy: synchroniser, bit timing, byte_vld / frame_err outputs.
- Decoder FSM, checksum, filter and timeout live in rx_cmd_frame.

Test Plan (tbit_period=10, DATA_BYTES=1, DEV_ID=8'h03, TMO_US=50):
1. Send A5 03 01 10 55 69 -> single cmdr_vld pulse 1 cycle after last byte_vld; dev=03 mod=01 addr=10 data=55; no error strobes.
2. Send A5 03 01 10 55 6A -> err_chk pulse, no cmdr_vld, cmdr_* keep values from scenario 1.
3. Send A5 04 01 10 55 6A -> no strobes at all. Then A5 FF 02 20 66 87 -> cmdr_vld with dev=FF.
4. Send A5 03 then a MOD byte with stop bit low -> err_frame. Then resend the scenario 1 frame -> accepted. Also: 00 11 A5 03 01 10 55 69 -> leading garbage ignored, frame accepted.
5. Send A5 03 01, then idle 51 pluse_us ticks -> err_tmo. Remaining 10 55 69 produces no strobe. Next full frame is accepted.
6. rx low pulse of 3 clocks while idle -> no byte_vld. Assert rst_n low after A5 03 -> all outputs 0; after release, a full frame is accepted normally.
